pc_seq: RTL
===========

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have parameter ADDR_N, default 16, meaning program counter width in bits.
REQ-002 The block SHALL have parameter DATA_N, default 8, meaning data byte-lane width in bits; ADDR_N SHALL be an integer multiple of DATA_N, with LANES = ADDR_N/DATA_N and LW = max(1, clog2(LANES)).
REQ-003 The block SHALL have parameter RESET_VEC, default 16'hfffc (ADDR_N bits), meaning the PC value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port addr_oe, input, 1 bit: address bus output enable.
REQ-007 The block SHALL have port addr, output, ADDR_N bits: carries PC when addr_oe=1, and is high-impedance otherwise.
REQ-008 The block SHALL have port inc, input, 1 bit: increment PC.
REQ-009 The block SHALL have ports load (input, 1 bit) and load_val (input, ADDR_N bits): load the full PC.
REQ-010 The block SHALL have ports wr_en (input, 1 bit), wr_lane (input, LW bits) and wr_data (input, DATA_N bits): byte-lane write.
REQ-011 The block SHALL have ports rd_lane (input, LW bits) and rd_data (output, DATA_N bits): combinational lane read, rd_data = PC[rd_lane*DATA_N +: DATA_N].
REQ-012 The block SHALL have ports br (input, 1 bit) and br_off (input, DATA_N bits, two's complement): relative branch request.
REQ-013 The block SHALL have port busy, output, 1 bit: branch page fix-up in progress.
REQ-014 The block SHALL have port page_cross, output, 1 bit: one-cycle pulse indicating a branch crossed a page.

Function
REQ-015 The block SHALL implement a two-state FSM with states IDLE and FIX; busy SHALL be 1 exactly when the state is FIX.
REQ-016 In IDLE, one command SHALL be executed per cycle in priority order br > load > inc > wr_en; lower-priority requests in the same cycle SHALL be ignored.
REQ-017 On inc, PC SHALL become (PC+1) mod 2^ADDR_N, with a full-width carry across all lanes (e.g. 16'hffff -> 16'h0000).
REQ-018 On load, PC SHALL become load_val on the next edge.
REQ-019 On wr_en, only lane wr_lane SHALL be replaced by wr_data, and all other lanes SHALL be unchanged; a wr_lane value >= LANES SHALL cause no change.
REQ-020 On br, the low lane L0 SHALL become (L0 + sign-extended br_off) mod 2^DATA_N on the next edge, and the upper lanes SHALL be unchanged in that cycle.
REQ-021 If the br addition produces neither a carry out of L0 (positive offset) nor a borrow (negative offset), the state SHALL remain IDLE, the branch SHALL complete in 1 cycle, and page_cross SHALL stay 0.
REQ-022 On a carry or borrow, the state SHALL go to FIX and the block SHALL record the direction (up or down).
REQ-023 In FIX, on the next edge, PC[ADDR_N-1:DATA_N] SHALL be incremented (up) or decremented (down) modulo 2^(ADDR_N-DATA_N), the state SHALL return to IDLE, and page_cross SHALL be 1 for exactly the following cycle.
REQ-024 In FIX, the inputs inc, load, wr_en and br SHALL be ignored, and upstream SHALL hold requests while busy=1.
REQ-025 A branch from the top page crossing upward SHALL wrap the high part to 0 (e.g. 16'hfff0 + 8'h20 -> 16'h0010), and one from the bottom page crossing downward SHALL wrap to all-ones.
REQ-026 br_off = 0 SHALL leave PC unchanged, SHALL take 1 cycle, and SHALL produce no page_cross.
REQ-027 The addr and rd_data outputs SHALL reflect the registered PC only, with no combinational path from any command input.
REQ-028 When LANES = 1, the block SHALL never enter FIX; the branch SHALL be a full-width modulo add, and page_cross SHALL stay 0.

Reset
REQ-029 While reset=1, independent of clk, the block SHALL force PC = RESET_VEC, state = IDLE, busy = 0, page_cross = 0, and direction = up.
REQ-030 An assertion of reset during FIX SHALL abort the fix-up without any high-part update, and after release the block SHALL accept commands in the first cycle.
REQ-031 After reset, addr SHALL be high-impedance unless addr_oe=1, and rd_data SHALL equal the selected lane of RESET_VEC.

Verification
REQ-032 The bench SHALL cover: reset pulse -> PC = 16'hfffc, rd_lane=1 gives rd_data = 8'hff, busy = 0.
REQ-033 The bench SHALL cover: load 16'h12fe, then inc three times -> 16'h12ff, 16'h1300, 16'h1301; inc at 16'hffff -> 16'h0000.
REQ-034 The bench SHALL cover: PC = 16'h1210, br with br_off = 8'h05 -> 16'h1215 after 1 cycle, busy and page_cross stay 0.
REQ-035 The bench SHALL cover: PC = 16'h12f0, br with br_off = 8'h20 -> 16'h1210 after cycle 1 with busy = 1, then 16'h1310 after cycle 2 with a page_cross pulse; inc held during FIX is ignored.
REQ-036 The bench SHALL cover: PC = 16'h1205, br with br_off = 8'hf0 (-16) -> 16'h11f5 after 2 cycles; reset asserted during FIX -> PC = 16'hfffc, busy = 0.
REQ-037 The bench SHALL cover: br, load, inc and wr_en all asserted together in IDLE -> only the branch is executed; wr_en with wr_lane=1 and wr_data = 8'hab at 16'h1234 -> 16'hab34.

Source files
------------

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter with lane access and paged relative branch
// Branches add into the low lane only; a carry/borrow costs one extra FIX cycle to adjust the page.
module pc_seq #(
  parameter int                ADDR_N    = 16,
  parameter int                DATA_N    = 8,
  parameter logic [ADDR_N-1:0] RESET_VEC = 16'hfffc,
  localparam int               LANES     = ADDR_N / DATA_N,
  localparam int               LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_oe,
  output logic [ADDR_N-1:0] addr,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_N-1:0] load_val,
  input  logic              wr_en,
  input  logic [LW-1:0]     wr_lane,
  input  logic [DATA_N-1:0] wr_data,
  input  logic [LW-1:0]     rd_lane,
  output logic [DATA_N-1:0] rd_data,
  input  logic              br,
  input  logic [DATA_N-1:0] br_off,
  output logic              busy,
  output logic              page_cross
);

  typedef enum logic {IDLE, FIX} state_t;

  state_t            state_q;
  logic [ADDR_N-1:0] pc_q;
  logic              dir_up_q;
  logic              page_cross_q;

  logic [ADDR_N-1:0] inc_d;
  logic [ADDR_N-1:0] wr_d;
  logic [ADDR_N-1:0] br_d;
  logic [ADDR_N-1:0] fix_d;
  logic              br_cross;
  logic              br_up;

  assign inc_d = pc_q + ADDR_N'(1);

  // Unmatched lane indices (>= LANES) leave the PC untouched.
  always_comb begin
    wr_d = pc_q;
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane == LW'(i)) wr_d[i*DATA_N +: DATA_N] = wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rd_lane == LW'(i)) rd_data = pc_q[i*DATA_N +: DATA_N];
    end
  end

  generate
    if (LANES == 1) begin : g_one
      assign br_d     = pc_q + ADDR_N'($signed(br_off));
      assign br_cross = 1'b0;
      assign br_up    = 1'b1;
      assign fix_d    = pc_q;
    end else begin : g_multi
      logic [DATA_N:0] lo_sum;
      assign lo_sum   = {1'b0, pc_q[DATA_N-1:0]} + {1'b0, br_off};
      assign br_d     = {pc_q[ADDR_N-1:DATA_N], lo_sum[DATA_N-1:0]};
      assign br_up    = ~br_off[DATA_N-1];
      // With a negative offset the unsigned add carries exactly when no borrow occurred.
      assign br_cross = br_up ? lo_sum[DATA_N] : ~lo_sum[DATA_N];
      assign fix_d    = {dir_up_q ? pc_q[ADDR_N-1:DATA_N] + (ADDR_N-DATA_N)'(1)
                                  : pc_q[ADDR_N-1:DATA_N] - (ADDR_N-DATA_N)'(1),
                         pc_q[DATA_N-1:0]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VEC;
      dir_up_q     <= 1'b1;
      page_cross_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          page_cross_q <= 1'b0;
          if (br) begin
            pc_q <= br_d;
            if (br_cross) begin
              state_q  <= FIX;
              dir_up_q <= br_up;
            end
          end else if (load) begin
            pc_q <= load_val;
          end else if (inc) begin
            pc_q <= inc_d;
          end else if (wr_en) begin
            pc_q <= wr_d;
          end
        end
        FIX: begin
          pc_q         <= fix_d;
          state_q      <= IDLE;
          page_cross_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr       = addr_oe ? pc_q : 'z;
  assign busy       = (state_q == FIX);
  assign page_cross = page_cross_q;

endmodule
